// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller: FSM states,
// glyph table (a..g in bits 6..0, active-high) and the per-digit register entry.
package seg_scan_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [6:0] GLYPH [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef struct packed {
    logic [3:0] val;
    logic       dp;
    logic       blank;
    logic       blink;
  } digit_t;

  localparam digit_t DIGIT_RST = '{val: 4'd0, dp: 1'b0, blank: 1'b1, blink: 1'b0};

endpackage

// File: rtl/seg_hex_dec.sv
// Hex digit + decimal point to active-low segment bus {a..g, dp}.
module seg_hex_dec
  import seg_scan_pkg::*;
(
  input  logic [3:0] val_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = ~{GLYPH[val_i], dp_i};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank with
// double-buffered digit registers. Optional blink support: SEG_SCAN_BLINK_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV          = 50000,
  parameter int BLANK_CYC    = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_idx,
  input  logic [3:0]            wr_val,
  input  logic                  wr_dp,
  input  logic                  wr_blank,
  input  logic                  wr_blink,
  output logic [7:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  frame_done
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_START = CW'(DIV - BLANK_CYC);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [3:0]    ND        = 4'(NUM_DIGITS);

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  commit;
  logic                  wr_ready_q;
  logic                  wr_hit;
  digit_t                wr_ent;
  digit_t                shadow_q [NUM_DIGITS];
  digit_t                active_q [NUM_DIGITS];
  digit_t                cur;
  logic                  blink_on_d;
  logic                  dark;
  logic [7:0]            glyph;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q;

  // One counter spans the whole slot; SHOW/GAP is just which part of it we are in.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
        SHOW, GAP: begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = SHOW;
            if (idx_q == LAST_IDX) begin
              idx_d  = '0;
              commit = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_d >= GAP_START) ? GAP : SHOW;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_hit = wr_valid && wr_ready_q && ({1'b0, wr_idx} < ND);

  always_comb begin
    wr_ent = '{val: wr_val, dp: wr_dp, blank: wr_blank, blink: 1'b0};
`ifdef SEG_SCAN_BLINK_EN
    wr_ent.blink = wr_blink;
`endif
  end

  // A write landing on the commit edge goes to shadow only; active takes the old shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= DIGIT_RST;
        active_q[i] <= DIGIT_RST;
      end
      wr_ready_q <= 1'b0;
    end else begin
      wr_ready_q <= 1'b1;
      if (wr_hit) shadow_q[wr_idx[IW-1:0]] <= wr_ent;
      if (commit) active_q <= shadow_q;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q;

  always_comb begin
    fcnt_d     = fcnt_q;
    blink_on_d = phase_q;
    if (!en) begin
      fcnt_d     = '0;
      blink_on_d = 1'b1;
    end else if (commit) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d     = '0;
        blink_on_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= blink_on_d;
    end
  end
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_blink;
  assign unused_blink = wr_blink;
  assign blink_on_d   = 1'b1;
`endif

  // Outputs are decoded from next-state values so seg_o and an_o register together.
  assign cur  = commit ? shadow_q[idx_d] : active_q[idx_d];
  assign dark = cur.blank | (cur.blink & ~blink_on_d);

  seg_hex_dec u_dec (
    .val_i (cur.val),
    .dp_i  (cur.dp),
    .seg_o (glyph)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    if (state_d == SHOW) begin
      an_d[idx_d] = 1'b0;
      if (!dark) seg_d = glyph;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= SEG_OFF;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= commit;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign seg_o      = seg_q;
  assign an_o       = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 dead cycles).
module tb_seg_scan_ctrl;

  localparam int ND      = 4;
  localparam int DIV     = 8;
  localparam int BLK     = 2;
  localparam int SLOT_ON = DIV - BLK;
  localparam int FRAME   = ND * DIV;

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic          wr_valid = 1'b0, wr_dp = 1'b0, wr_blank = 1'b0, wr_blink = 1'b0;
  logic [2:0]    wr_idx = '0;
  logic [3:0]    wr_val = '0;
  logic          wr_ready, frame_done;
  logic [7:0]    seg_o;
  logic [ND-1:0] an_o;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DIV), .BLANK_CYC(BLK), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_val(wr_val),
    .wr_dp(wr_dp), .wr_blank(wr_blank), .wr_blink(wr_blink),
    .seg_o(seg_o), .an_o(an_o), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed { logic [3:0] val; logic dp; logic blank; } ent_t;
  typedef struct packed { logic [ND-1:0] an; logic [7:0] seg; } slot_t;

  localparam logic [6:0] GL [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  ent_t  m_sh [ND], m_act [ND], sh_snap [ND];
  slot_t sb [$];

  function automatic slot_t exp_slot(int d);
    slot_t s;
    logic [ND-1:0] one = 1;
    s.an  = ~(one << d);
    s.seg = m_act[d].blank ? 8'hFF : ~{GL[m_act[d].val], m_act[d].dp};
    return s;
  endfunction

  task automatic push_frame();
    for (int d = 0; d < ND; d++) sb.push_back(exp_slot(d));
  endtask

  // Monitor: models shadow/active, pops one expected slot per lit run.
  logic  in_slot = 1'b0, abort = 1'b0, have_fd = 1'b0, pend_v = 1'b0;
  int    slot_len = 0, fd_cnt = 0;
  int    pend_idx = 0;
  ent_t  pend_e;
  slot_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      in_slot = 1'b0; have_fd = 1'b0; pend_v = 1'b0;
      for (int d = 0; d < ND; d++) m_sh[d] = '{4'd0, 1'b0, 1'b1};
      m_act = m_sh;
      sh_snap = m_sh;
    end else begin
      if (frame_done) begin
        if (have_fd) chk("frame_period", fd_cnt, FRAME);
        have_fd = 1'b1;
        fd_cnt  = 0;
        m_act   = sh_snap;
        push_frame();
      end
      fd_cnt++;
      if (an_o != '1) begin
        if (!in_slot) begin
          in_slot = 1'b1; slot_len = 0; abort = 1'b0;
          chk("slot_queued", sb.size() > 0, 1);
          if (sb.size() > 0) cur = sb.pop_front();
        end
        slot_len++;
        chk("slot_an", an_o, cur.an);
        chk("slot_seg", seg_o, cur.seg);
      end else begin
        if (in_slot && !abort) chk("slot_len", slot_len, SLOT_ON);
        in_slot = 1'b0;
        chk("dark_seg", seg_o, 8'hFF);
      end
      if (!en) begin
        sb.delete();
        have_fd = 1'b0;
        abort   = 1'b1;
      end
      if (pend_v) m_sh[pend_idx] = pend_e;
      sh_snap  = m_sh;
      pend_v   = wr_valid && wr_ready && (wr_idx < ND);
      pend_idx = int'(wr_idx[1:0]);
      pend_e   = '{wr_val, wr_dp, wr_blank};
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(logic [2:0] idx, logic [3:0] v, logic dp, logic blank);
    wr_valid = 1'b1; wr_idx = idx; wr_val = v; wr_dp = dp; wr_blank = blank;
    chk("wr_ready", wr_ready, 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_fd();
    int k = 0;
    logic seen = 1'b0;
    while (!seen && k < 4 * FRAME) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      k++;
    end
    chk("frame_done_timeout", seen, 1);
  endtask

  initial begin
    step(3);
    chk("rst_seg", seg_o, 8'hFF);
    chk("rst_an", an_o, 4'hF);
    chk("rst_ready", wr_ready, 0);
    chk("rst_fd", frame_done, 0);
    rst_n = 1'b1;
    step(1);
    chk("ready_rise", wr_ready, 1);
    chk("idle_an", an_o, 4'hF);

    en = 1'b1;
    push_frame();
    repeat (3) wait_fd();

    step(5);
    write(3'd0, 4'h5, 1'b0, 1'b0);
    write(3'd3, 4'hF, 1'b1, 1'b0);
    wait_fd();
    chk("d0_five_an", an_o, 4'b1110);
    chk("d0_five_seg", seg_o, 8'h49);
    repeat (3 * DIV) @(negedge clk);
    chk("d3_fdp_an", an_o, 4'b0111);
    chk("d3_fdp_seg", seg_o, 8'h70);

    wait_fd();
    repeat (FRAME - 1) @(posedge clk);
    #1;
    write(3'd1, 4'h2, 1'b0, 1'b0);
    @(negedge clk);
    chk("commit_align", frame_done, 1);
    repeat (DIV) @(negedge clk);
    chk("late_wr_an", an_o, 4'b1101);
    chk("late_wr_hidden", seg_o, 8'hFF);
    wait_fd();
    repeat (DIV) @(negedge clk);
    chk("late_wr_shown", seg_o, 8'h25);

    step(1);
    write(3'd6, 4'h8, 1'b0, 1'b0);
    write(3'd0, 4'hA, 1'b1, 1'b0);
    write(3'd1, 4'hB, 1'b0, 1'b0);
    write(3'd2, 4'hC, 1'b1, 1'b1);
    write(3'd3, 4'hD, 1'b1, 1'b0);
    wait_fd();
    wait_fd();
    chk("burst_d0", seg_o, 8'h10);

    wait_fd();
    repeat (2 * DIV) @(negedge clk);
    step(1);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("drop_an", an_o, 4'hF);
    chk("drop_seg", seg_o, 8'hFF);
    step(3);
    chk("drop_fd", frame_done, 0);
    en = 1'b1;
    push_frame();
    @(negedge clk);
    @(negedge clk);
    chk("restart_d0", an_o, 4'b1110);
    wait_fd();
    wait_fd();

    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an", an_o, 4'hF);
    chk("arst_seg", seg_o, 8'hFF);
    chk("arst_ready", wr_ready, 0);
    #20;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode 7-segment bank of NUM_DIGITS digits sharing one segment bus.
- Holds per-digit hex value, decimal-point and blank flags in double-buffered registers, written through a valid/ready port.
- Sequences digit enables with anti-ghosting dead time.
- Drives active-low segments (bit7..1 = a..g, bit0 = dp; 0 = lit) via an internal 4-bit hex decoder.
- Sits between the system bus and board display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..8)
DIV, 50000, clk cycles per digit slot including dead time (> BLANK_CYC)
BLANK_CYC, 2, dead-time cycles at end of each slot, all anodes off
BLINK_FRAMES, 64, frames per blink half-period (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; 0 blanks display
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid&wr_ready
wr_idx  in  3  target digit
wr_val  in  4  hex value 0..F
wr_dp  in  1  decimal point on
wr_blank  in  1  digit dark
wr_blink  in  1  blink enable (honoured only with SEG_SCAN_BLINK_EN)
seg_o  out  8  segments a..g,dp, active-low
an_o  out  NUM_DIGITS  digit enables, active-low
frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (async assert, sync release):
  - seg_o=8'hFF, an_o all ones, wr_ready=0, frame_done=0.
  - Shadow and active registers: val=0, dp=0, blank=1, blink=0.
  - FSM IDLE, digit index 0, slot counter 0.
  - wr_ready rises on the first clk edge after release and stays 1.
- All outputs are registered. Decode of the active registers for the current index appears on seg_o in the same cycle that an_o selects that digit.
- Writes:
  - An accepted write updates the shadow entry wr_idx on the next edge.
  - wr_idx >= NUM_DIGITS is accepted and discarded.
  - Back-to-back writes are sustained at 1 per cycle.
- Commit: on the last cycle of the last digit's GAP, shadow is copied to active.
  - A write accepted in that same cycle lands in shadow only and becomes visible the following frame.
- FSM:
  - IDLE: an_o all 1, seg_o FF, index 0. If en=1, go to SHOW next cycle.
  - SHOW: an_o[index]=0 for DIV-BLANK_CYC cycles, then go to GAP.
  - GAP: an_o all 1, seg_o FF for BLANK_CYC cycles. Then index+1 and SHOW. After index NUM_DIGITS-1, wrap to 0, pulse frame_done for 1 cycle, commit, then SHOW.
  - en=0 in any state: next cycle IDLE, outputs dark, counters cleared, pending commit dropped (shadow kept).
- Blanked digit: an_o still asserts for its slot, but seg_o=FF; the dp flag is ignored.
- Decode: 0..9 as standard; A,b,C,d,E,F as standard hex glyphs. dp drives bit0 low when set.
- Slot counter width is clog2(DIV). No overflow is possible; the counter resets each slot.
- rst_n asserted mid-frame: all outputs go dark immediately (asynchronous).

Optional Feature:
SEG_SCAN_BLINK_EN:
- Defined:
  - Per-digit blink bit is stored in shadow and active registers.
  - A frame counter toggles a blink phase every BLINK_FRAMES frame_done pulses.
  - During the off phase, digits with blink=1 behave as blanked.
  - The phase resets to on, and the counter clears, on reset or en=0.
- Undefined: wr_blink is ignored; no frame counter or blink storage is synthesised.

Decomposition:
- Package seg_scan_pkg: FSM state enum (IDLE, SHOW, GAP), SEG_OFF=8'hFF, the 16-entry glyph constant table, digit-entry struct {val, dp, blank, blink}.
- Sub-module seg_hex_dec: combinational 4-bit value + dp → 8-bit active-low segments, shared by all digits.

Test Plan (NUM_DIGITS=4, DIV=8, BLANK_CYC=2):
- Reset then en=1, no writes → every slot: an_o low 6 cycles per digit in order 1110,1101,1011,0111; seg_o=FF throughout (blank=1); frame_done pulses every 32 cycles.
- Write idx0=5 dp=0, idx3=F dp=1, blank=0 mid-frame → unchanged until the commit edge; next frame shows digit0 seg_o=~8'b1011_0110 and digit3 seg_o=~8'b1000_1111.
- Write on the exact commit cycle → value appears one frame later, not in the frame that starts at that commit.
- en dropped during SHOW of digit2 → next cycle an_o=1111, seg_o=FF; on re-enable the scan restarts at digit0.
- wr_idx=6 write → accepted (wr_ready=1), no digit changes; 4 consecutive writes, one per cycle, all land.
- With SEG_SCAN_BLINK_EN, BLINK_FRAMES=2, digit1 blink=1 → digit1 lit 2 frames, dark 2 frames, repeating; other digits are unaffected.
